// File: rtl/irq_pkg.sv
// Shared definitions for the platform interrupt arbiter.
// Register byte offsets, FSM state encoding and the CSR cause number
// that intr_ext feeds (machine external interrupt, mip bit 11).
package irq_pkg;

  localparam logic [4:0] IRQ_PENDING = 5'h00;
  localparam logic [4:0] IRQ_ENABLE  = 5'h04;
  localparam logic [4:0] IRQ_EDGE    = 5'h08;
  localparam logic [4:0] IRQ_PRIO    = 5'h0C;
  localparam logic [4:0] IRQ_THRESH  = 5'h10;
  localparam logic [4:0] IRQ_CLAIM   = 5'h14;

  localparam int unsigned IRQ_EXT_CAUSE = 11;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    SERVICING = 1'b1
  } state_t;

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: 2-flop synchroniser, edge detect and pending flop.
// Latency: raw line to pending is 3 clock edges.
// No backpressure; edge mode holds a one-deep pending bit until cleared.
module irq_gateway (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  input  logic edge_mode,
  input  logic clear,
  input  logic in_service,
  output logic pending
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic pending_q, pending_d;
  logic rise;

  // Next-state for synchroniser, edge-detect copy and pending bit
  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise    = sync2_q & ~prev_q;
    if (edge_mode) begin
      // A new edge in the same cycle as a claim clear keeps the bit set
      pending_d = rise | (pending_q & ~clear);
    end else begin
      // Level sources are masked only while this source is being serviced
      pending_d = sync2_q & ~in_service;
    end
  end

  // State flops, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: priority/threshold selection plus claim/complete FSM.
// Latency: pending to intr_ext is 1 edge; claim takes effect on the read edge.
// No backpressure; one source in service, others stay pending until complete.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [4:0]         addr,
  input  logic [31:0]        data_in,
  input  logic               write_en,
  input  logic               read_en,
  output logic [31:0]        data_out,
  output logic               intr_ext
);

  localparam int PW = NUM_SRC * PRIO_W;

  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] edge_q, edge_d;
  logic [PW-1:0]      prio_q, prio_d;
  logic [PRIO_W-1:0]  thresh_q, thresh_d;
  state_t             state_q, state_d;
  logic [3:0]         in_service_id_q, in_service_id_d;
  logic               intr_ext_q, intr_ext_d;

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] clear;
  logic [3:0]         best_id;
  logic [PRIO_W-1:0]  best_prio;
  logic               claim_rd;
  logic               complete_wr;
  logic               unused_data;

  assign unused_data = ^data_in;
  assign claim_rd    = read_en && (addr == IRQ_CLAIM);
  assign complete_wr = write_en && (addr == IRQ_CLAIM);

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : gen_gw
      irq_gateway u_gw (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_src[g]),
        .edge_mode  (edge_q[g]),
        .clear      (clear[g]),
        .in_service ((state_q == SERVICING) && (in_service_id_q == 4'(g + 1))),
        .pending    (pending[g])
      );
    end
  endgenerate

  // Pick highest priority above threshold; strict compare keeps lowest index on ties
  always_comb begin
    best_id   = 4'd0;
    best_prio = thresh_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (enable_q[i] && pending[i] && (prio_q[i*PRIO_W +: PRIO_W] > best_prio)) begin
        best_prio = prio_q[i*PRIO_W +: PRIO_W];
        best_id   = 4'(i + 1);
      end
    end
  end

  // Software-writable configuration registers
  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    prio_d   = prio_q;
    thresh_d = thresh_q;
    if (write_en) begin
      case (addr)
        IRQ_ENABLE: enable_d = data_in[NUM_SRC-1:0];
        IRQ_EDGE:   edge_d   = data_in[NUM_SRC-1:0];
        IRQ_PRIO:   prio_d   = data_in[PW-1:0];
        IRQ_THRESH: thresh_d = data_in[PRIO_W-1:0];
        default:    ;
      endcase
    end
  end

  // Claim/complete FSM and the registered interrupt request
  always_comb begin
    state_d         = state_q;
    in_service_id_d = in_service_id_q;
    intr_ext_d      = 1'b0;
    clear           = '0;
    case (state_q)
      IDLE: begin
        intr_ext_d = (best_id != 4'd0);
        if (claim_rd && (best_id != 4'd0)) begin
          for (int i = 0; i < NUM_SRC; i++) begin
            if (best_id == 4'(i + 1)) clear[i] = 1'b1;
          end
          in_service_id_d = best_id;
          state_d         = SERVICING;
          intr_ext_d      = 1'b0;
        end
      end
      SERVICING: begin
        // Only the id currently in service may complete; others are dropped
        if (complete_wr && (data_in[3:0] == in_service_id_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register read mux; claim reads 0 while a source is in service
  always_comb begin
    data_out = 32'd0;
    case (addr)
      IRQ_PENDING: data_out = 32'(pending);
      IRQ_ENABLE:  data_out = 32'(enable_q);
      IRQ_EDGE:    data_out = 32'(edge_q);
      IRQ_PRIO:    data_out = 32'(prio_q);
      IRQ_THRESH:  data_out = 32'(thresh_q);
      IRQ_CLAIM:   data_out = (state_q == IDLE) ? 32'(best_id) : 32'd0;
      default:     data_out = 32'd0;
    endcase
  end

  // All arbiter state flops, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q        <= '0;
      edge_q          <= '0;
      prio_q          <= '0;
      thresh_q        <= '0;
      state_q         <= IDLE;
      in_service_id_q <= 4'd0;
      intr_ext_q      <= 1'b0;
    end else begin
      enable_q        <= enable_d;
      edge_q          <= edge_d;
      prio_q          <= prio_d;
      thresh_q        <= thresh_d;
      state_q         <= state_d;
      in_service_id_q <= in_service_id_d;
      intr_ext_q      <= intr_ext_d;
    end
  end

  assign intr_ext = intr_ext_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: reset, latency, priority, threshold,
// level sources, re-queue during service and asynchronous reset.
// Inputs change on the falling edge; outputs are sampled between edges.
module tb_irq_arbiter;

  logic        clk;
  logic        reset;
  logic [7:0]  irq_src;
  logic [4:0]  addr;
  logic [31:0] data_in;
  logic        write_en;
  logic        read_en;
  logic [31:0] data_out;
  logic        intr_ext;

  int checks;
  int errors;

  irq_arbiter #(.NUM_SRC(8), .PRIO_W(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_src  (irq_src),
    .addr     (addr),
    .data_in  (data_in),
    .write_en (write_en),
    .read_en  (read_en),
    .data_out (data_out),
    .intr_ext (intr_ext)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    addr     = a;
    data_in  = d;
    write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic reg_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    addr    = a;
    read_en = 1'b1;
    #1 d = data_out;
    @(negedge clk);
    read_en = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] m);
    @(negedge clk);
    irq_src = irq_src | m;
    @(negedge clk);
    irq_src = irq_src & ~m;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [4:0]  a;
    if (intr_ext !== 1'b0) begin
      errors++; $display("FAIL reset_intr: got %0b want 0", intr_ext);
    end
    checks++;
    for (int i = 0; i < 6; i++) begin
      a = 5'(i * 4);
      reg_read(a, d);
      checks++;
      if (d !== 32'd0) begin
        errors++; $display("FAIL reset_reg_%0h: got %0h want 0", a, d);
      end
    end
  endtask

  task automatic test_basic_latency();
    logic [31:0] d;
    reg_write(5'h04, 32'h01);
    reg_write(5'h08, 32'h01);
    reg_write(5'h0C, 32'h01);
    reg_write(5'h10, 32'h00);
    reg_write(5'h18, 32'hFFFF_FFFF);
    reg_read(5'h18, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL unmapped_read: got %0h want 0", d);
    end
    @(negedge clk);
    irq_src = 8'h01;
    @(posedge clk);
    #1 irq_src = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1 addr = 5'h00;
    #1;
    checks++;
    if (data_out !== 32'h01) begin
      errors++; $display("FAIL lat_pending_e3: got %0h want 1", data_out);
    end
    checks++;
    if (intr_ext !== 1'b0) begin
      errors++; $display("FAIL lat_intr_e3: got %0b want 0", intr_ext);
    end
    @(posedge clk);
    #1;
    checks++;
    if (intr_ext !== 1'b1) begin
      errors++; $display("FAIL lat_intr_e4: got %0b want 1", intr_ext);
    end
    reg_read(5'h14, d);
    checks++;
    if (d !== 32'd1) begin
      errors++; $display("FAIL basic_claim: got %0d want 1", d);
    end
    reg_read(5'h00, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL basic_pending_after_claim: got %0h want 0", d);
    end
    checks++;
    if (intr_ext !== 1'b0) begin
      errors++; $display("FAIL basic_intr_after_claim: got %0b want 0", intr_ext);
    end
    reg_write(5'h00, 32'hFF);
    reg_read(5'h00, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL pending_ro: got %0h want 0", d);
    end
    reg_write(5'h14, 32'd1);
    tick(3);
    checks++;
    if (intr_ext !== 1'b0) begin
      errors++; $display("FAIL basic_idle_intr: got %0b want 0", intr_ext);
    end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    logic [31:0] exp_ids [3];
    exp_ids[0] = 32'd3; exp_ids[1] = 32'd6; exp_ids[2] = 32'd2;
    reg_write(5'h04, 32'h26);
    reg_write(5'h08, 32'h26);
    reg_write(5'h0C, 32'hC38);
    reg_read(5'h0C, d);
    checks++;
    if (d !== 32'hC38) begin
      errors++; $display("FAIL prio_readback: got %0h want c38", d);
    end
    pulse(8'h26);
    tick(4);
    checks++;
    if (intr_ext !== 1'b1) begin
      errors++; $display("FAIL prio_intr: got %0b want 1", intr_ext);
    end
    for (int r = 0; r < 3; r++) begin
      reg_read(5'h14, d);
      checks++;
      if (d !== exp_ids[r]) begin
        errors++; $display("FAIL prio_claim_round%0d: got %0d want %0d", r, d, exp_ids[r]);
      end
      reg_write(5'h14, exp_ids[r]);
      tick(2);
    end
    reg_read(5'h14, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL prio_claim_empty: got %0d want 0", d);
    end
    reg_write(5'h0C, 32'hFFFF_FFFF);
    reg_read(5'h0C, d);
    checks++;
    if (d !== 32'h0000_FFFF) begin
      errors++; $display("FAIL prio_width: got %0h want ffff", d);
    end
  endtask

  task automatic test_threshold();
    logic [31:0] d;
    reg_write(5'h04, 32'h08);
    reg_write(5'h08, 32'h08);
    reg_write(5'h0C, 32'h40);
    reg_write(5'h10, 32'hFF);
    reg_read(5'h10, d);
    checks++;
    if (d !== 32'd3) begin
      errors++; $display("FAIL thresh_width: got %0h want 3", d);
    end
    reg_write(5'h10, 32'h01);
    pulse(8'h08);
    tick(5);
    checks++;
    if (intr_ext !== 1'b0) begin
      errors++; $display("FAIL thresh_block_intr: got %0b want 0", intr_ext);
    end
    reg_read(5'h14, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL thresh_block_claim: got %0d want 0", d);
    end
    reg_write(5'h10, 32'h00);
    checks++;
    if (intr_ext !== 1'b0) begin
      errors++; $display("FAIL thresh_open_early: got %0b want 0", intr_ext);
    end
    @(posedge clk);
    #1;
    checks++;
    if (intr_ext !== 1'b1) begin
      errors++; $display("FAIL thresh_open_intr: got %0b want 1", intr_ext);
    end
    reg_read(5'h14, d);
    checks++;
    if (d !== 32'd4) begin
      errors++; $display("FAIL thresh_claim: got %0d want 4", d);
    end
    reg_write(5'h14, 32'd4);
  endtask

  task automatic test_level();
    logic [31:0] d;
    reg_write(5'h04, 32'h10);
    reg_write(5'h08, 32'h00);
    reg_write(5'h0C, 32'h200);
    @(negedge clk);
    irq_src = 8'h10;
    tick(5);
    checks++;
    if (intr_ext !== 1'b1) begin
      errors++; $display("FAIL level_intr: got %0b want 1", intr_ext);
    end
    reg_read(5'h14, d);
    checks++;
    if (d !== 32'd5) begin
      errors++; $display("FAIL level_claim: got %0d want 5", d);
    end
    tick(2);
    reg_read(5'h00, d);
    checks++;
    if (d !== 32'h00) begin
      errors++; $display("FAIL level_pending_in_service: got %0h want 0", d);
    end
    reg_write(5'h14, 32'd5);
    addr = 5'h00;
    @(posedge clk);
    #1;
    checks++;
    if (data_out !== 32'h10) begin
      errors++; $display("FAIL level_pending_after_complete: got %0h want 10", data_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (intr_ext !== 1'b1) begin
      errors++; $display("FAIL level_reassert: got %0b want 1", intr_ext);
    end
    @(negedge clk);
    irq_src = 8'h00;
    tick(6);
    checks++;
    if (intr_ext !== 1'b0) begin
      errors++; $display("FAIL level_release: got %0b want 0", intr_ext);
    end
  endtask

  task automatic test_requeue_and_reset();
    logic [31:0] d;
    logic [4:0]  a;
    reg_write(5'h04, 32'h01);
    reg_write(5'h08, 32'h01);
    reg_write(5'h0C, 32'h01);
    pulse(8'h01);
    tick(5);
    reg_read(5'h14, d);
    checks++;
    if (d !== 32'd1) begin
      errors++; $display("FAIL requeue_claim1: got %0d want 1", d);
    end
    pulse(8'h01);
    tick(5);
    reg_read(5'h00, d);
    checks++;
    if (d !== 32'h01) begin
      errors++; $display("FAIL requeue_pending: got %0h want 1", d);
    end
    reg_write(5'h14, 32'd7);
    tick(3);
    checks++;
    if (intr_ext !== 1'b0) begin
      errors++; $display("FAIL wrong_id_intr: got %0b want 0", intr_ext);
    end
    reg_read(5'h14, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL wrong_id_claim: got %0d want 0", d);
    end
    reg_write(5'h14, 32'd1);
    tick(2);
    checks++;
    if (intr_ext !== 1'b1) begin
      errors++; $display("FAIL requeue_reassert: got %0b want 1", intr_ext);
    end
    reg_read(5'h14, d);
    checks++;
    if (d !== 32'd1) begin
      errors++; $display("FAIL requeue_claim2: got %0d want 1", d);
    end
    // now in service with config loaded; reset asynchronously between edges
    reg_write(5'h10, 32'h01);
    reg_write(5'h0C, 32'h03);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (intr_ext !== 1'b0) begin
      errors++; $display("FAIL async_reset_intr: got %0b want 0", intr_ext);
    end
    for (int i = 0; i < 6; i++) begin
      a = 5'(i * 4);
      addr = a;
      #1;
      checks++;
      if (data_out !== 32'd0) begin
        errors++; $display("FAIL async_reset_reg_%0h: got %0h want 0", a, data_out);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    irq_src  = 8'h00;
    addr     = 5'h00;
    data_in  = 32'd0;
    write_en = 1'b0;
    read_en  = 1'b0;
    #25 reset = 1'b0;
    test_reset();
    test_basic_latency();
    test_priority();
    test_threshold();
    test_level();
    test_requeue_and_reset();
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Platform-level interrupt arbiter between peripheral interrupt lines and the CSR block's external interrupt input (intr_ext, mip bit 11).
- Synchronises NUM_SRC asynchronous sources and latches them as pending (edge- or level-triggered).
- Picks the highest-priority enabled source above a threshold and runs a claim/complete handshake with the ISR, one source in service at a time.
- Sits on the memory-mapped peripheral bus next to the timer and UART.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..15).
- PRIO_W, 2, priority field width per source; priority 0 = never interrupts.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- irq_src  in  NUM_SRC  raw asynchronous interrupt lines
- addr  in  5  register byte offset
- data_in  in  32  write data
- write_en  in  1  register write strobe
- read_en  in  1  register read strobe (claim side effect)
- data_out  out  32  combinational read data
- intr_ext  out  1  registered interrupt request to csr

Behaviour:
- Register map:
  - 0x00 pending (RO)
  - 0x04 enable mask
  - 0x08 edge_mode (1 = edge, 0 = level)
  - 0x0C priority (PRIO_W bits per source, source i at bits [i*PRIO_W +: PRIO_W])
  - 0x10 threshold
  - 0x14 claim (read) / complete (write)
  - Any other offset reads 0; writes to it are ignored.
- Reset (async): pending, enable, edge_mode, priority, threshold, sync flops = 0; state = IDLE; intr_ext = 0; in_service_id = 0.
- Per source, in order:
  - 2-flop synchroniser, then a registered copy for edge detect.
  - Edge mode: a rising edge of the synced signal sets pending.
  - Level mode: pending = synced level AND NOT (in service AND id matches).
- Latency: irq_src high before edge 1 → pending visible after edge 3 → intr_ext high after edge 4.
- Candidate selection (combinational): enabled AND pending AND priority > threshold.
  - Highest priority wins.
  - Ties go to the lowest index.
  - best_id = index+1; 0 = none.
- FSM IDLE:
  - intr_ext <= (best_id != 0), registered.
  - read_en at 0x14 returns best_id.
  - If best_id != 0: clear that source's edge pending bit, latch in_service_id, go to SERVICING, intr_ext <= 0 next edge.
  - If best_id == 0: return 0 and stay IDLE.
- FSM SERVICING:
  - intr_ext held 0.
  - A claim read returns 0.
  - Edge-mode edges on any source, including the one in service, still set pending (one-deep queue).
  - write_en at 0x14 with data_in[3:0] == in_service_id → IDLE next edge. A mismatching id is ignored.
- Simultaneous events:
  - Claim clear and new edge on the same source in the same cycle: set wins, pending stays 1.
  - Complete in IDLE: ignored.
  - Software writes to 0x00: ignored.
- Masking: clearing an enable bit while that source is in service does not abort service; complete is still required.
- Reset mid-service: everything returns to reset values asynchronously; intr_ext drops immediately.
- Width rules:
  - priority register bits above NUM_SRC*PRIO_W read 0.
  - threshold uses data_in[PRIO_W-1:0].
  - Unused pending/enable/edge_mode bits read 0.

Decomposition:
- Shared package irq_pkg holds:
  - register offset localparams (IRQ_PENDING … IRQ_CLAIM);
  - the fsm state enum (IDLE, SERVICING);
  - the CSR external cause value 11.
- One sub-module irq_gateway (one instance per source): synchroniser, edge detect, pending flop, with inputs edge_mode, clear, in_service.
- Arbitration tree and FSM live in irq_arbiter.

Test Plan:
- Setup: enable=0x01, edge_mode=0x01, priority src0=1, threshold=0. Pulse irq_src[0] for 1 cycle. Expect pending=0x01 after edge 3 and intr_ext=1 after edge 4. Claim read returns 1; pending then reads 0 and intr_ext=0. Write 1 to 0x14 → IDLE.
- Priority and tie-break: src2 prio 3, src5 prio 3, src1 prio 2, all pending. Successive claim/complete rounds return 3, 6, 2; tie between src2 and src5 goes to src2 (lowest index).
- Threshold: src3 prio 1, threshold=1. intr_ext stays 0 and claim returns 0. Set threshold=0 → intr_ext=1 one edge later.
- Level source src4 held high through claim. pending[4] reads 0 during service. Complete 5 → pending[4]=1 and intr_ext=1 again.
- During SERVICING of src0, a new edge on src0 sets pending[0]. Complete with wrong id 7: state unchanged. Complete 1 → intr_ext re-asserts, claim returns 1.
- Assert reset mid-SERVICING: intr_ext=0 and all registers read 0 without a clock edge.
